// File: rtl/arbitro_pilha_pkg.sv
// Shared encodings for the stack arbiter: FSM states, stack operation and
// requester identity.
package arbitro_pilha_pkg;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      EMITE    = 2'd1,
      ESPERA   = 2'd2,
      RESPOSTA = 2'd3
   } estado_e;

   typedef enum logic {
      OP_POP  = 1'b0,
      OP_PUSH = 1'b1
   } op_e;

   typedef enum logic {
      REQ_UC  = 1'b0,
      REQ_ULA = 1'b1
   } requisitante_e;

   // The ALU always delivers a full 32-bit result, independent of the stack width.
   localparam int LARGURA_ULA = 32;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered
// last-served requester. After reset the ULA counts as last served, so UC
// wins the first contested grant.
module arbitro_rr2
   import arbitro_pilha_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req,
   input  logic          atualiza,
   output logic [1:0]    gnt,
   output requisitante_e ultimo
);

   // Grant the lone requester, or the one not served last when both request.
   always_comb begin
      // NOTE: default assignment first so no path leaves gnt unassigned (no latch).
      gnt = req;
      if (req[0] && req[1]) begin
         gnt = (ultimo == REQ_ULA) ? 2'b01 : 2'b10;
      end
   end

   // Remember who was served, only when the owner actually commits a grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ultimo <= REQ_ULA;
      end else if (atualiza && (gnt != 2'b00)) begin
         ultimo <= gnt[1] ? REQ_ULA : REQ_UC;
      end
   end

endmodule

// File: rtl/arbitro_pilha.sv
// Arbitrates stack access between the control unit (UC) and the ALU (ULA),
// tracks stack occupancy and rejects overflowing pushes / underflowing pops.
module arbitro_pilha
   import arbitro_pilha_pkg::*;
#(
   parameter int PROF    = 16,
   parameter int LARGURA = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   uc_req,
   input  logic                   uc_op,
   input  logic [LARGURA-1:0]     uc_din,
   output logic                   uc_ack,
   input  logic                   ula_req,
   input  logic                   ula_op,
   input  logic [LARGURA_ULA-1:0] ula_din,
   output logic                   ula_ack,
   output logic [LARGURA-1:0]     resp_data,
   output logic                   resp_err,
   output logic                   pilha_en,
   output logic                   pilha_wren,
   output logic                   pilha_controle,
   output logic [LARGURA-1:0]     pilha_din_uc,
   output logic [LARGURA_ULA-1:0] pilha_din_ula,
   input  logic [LARGURA-1:0]     pilha_dout,
   output logic [$clog2(PROF):0]  nivel,
   output logic                   cheia,
   output logic                   vazia
);

   localparam int             NW        = $clog2(PROF) + 1;
   localparam logic [NW-1:0]  NIVEL_MAX = NW'(PROF);
   localparam logic [NW-1:0]  UM        = NW'(1);

   estado_e       estado;
   op_e           op_q;
   op_e           op_g;
   requisitante_e ultimo;    // doubles as "granted requester" after a grant
   requisitante_e sel_g;
   logic [1:0]    gnt;
   logic          concede;
   logic          rejeita;

   arbitro_rr2 u_rr (
      .clk      (clk),
      .rst      (rst),
      .req      ({ula_req, uc_req}),
      .atualiza (estado == OCIOSO),
      .gnt      (gnt),
      .ultimo   (ultimo)
   );

   assign cheia = (nivel == NIVEL_MAX);
   assign vazia = (nivel == '0);

   // Decode the winning requester's operation and whether it must be refused.
   always_comb begin
      concede = (gnt != 2'b00);
      sel_g   = gnt[1] ? REQ_ULA : REQ_UC;
      op_g    = op_e'((sel_g == REQ_ULA) ? ula_op : uc_op);
      rejeita = ((op_g == OP_PUSH) && cheia) || ((op_g == OP_POP) && vazia);
   end

   // Main FSM with registered stack strobes, acks, response and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado         <= OCIOSO;
         op_q           <= OP_POP;
         pilha_en       <= 1'b0;
         pilha_wren     <= 1'b0;
         pilha_controle <= 1'b0;
         pilha_din_uc   <= '0;
         pilha_din_ula  <= '0;
         uc_ack         <= 1'b0;
         ula_ack        <= 1'b0;
         resp_data      <= '0;
         resp_err       <= 1'b0;
         nivel          <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values; these defaults make strobes single-cycle.
         pilha_en <= 1'b0;
         uc_ack   <= 1'b0;
         ula_ack  <= 1'b0;
         unique case (estado)
            OCIOSO: begin
               resp_data <= '0;
               resp_err  <= 1'b0;
               if (concede) begin
                  op_q           <= op_g;
                  pilha_wren     <= op_g;
                  pilha_controle <= sel_g;
                  if (sel_g == REQ_ULA) pilha_din_ula <= ula_din;
                  else                  pilha_din_uc  <= uc_din;
                  if (rejeita) begin
                     resp_err <= 1'b1;
                     if (sel_g == REQ_ULA) ula_ack <= 1'b1;
                     else                  uc_ack  <= 1'b1;
                     estado <= RESPOSTA;
                  end else begin
                     pilha_en <= 1'b1;
                     estado   <= EMITE;
                  end
               end
            end
            EMITE: begin
               if (op_q == OP_PUSH) begin
                  if (nivel != NIVEL_MAX) nivel <= nivel + UM;
                  if (ultimo == REQ_ULA) ula_ack <= 1'b1;
                  else                   uc_ack  <= 1'b1;
                  estado <= RESPOSTA;
               end else begin
                  if (nivel != '0) nivel <= nivel - UM;
                  estado <= ESPERA;
               end
            end
            ESPERA: begin
               resp_data <= pilha_dout;
               if (ultimo == REQ_ULA) ula_ack <= 1'b1;
               else                   uc_ack  <= 1'b1;
               estado <= RESPOSTA;
            end
            RESPOSTA: begin
               resp_data <= '0;
               resp_err  <= 1'b0;
               estado    <= OCIOSO;
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

endmodule

// File: doc/arbitro_pilha.md
ARBITRO_PILHA -- requirements
Module: arbitro_pilha

Interface
REQ-001 SHALL have parameter PROF, default 16, stack depth in words.
REQ-002 SHALL have parameter LARGURA, default 16, stack word width in bits.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: uc_req in 1 request; uc_op in 1 (1=push, 0=pop); uc_din in LARGURA push data; uc_ack out 1 one-cycle done pulse.
REQ-006 SHALL have ports: ula_req in 1 request; ula_op in 1 (1=push, 0=pop); ula_din in 32 push data (ALU result); ula_ack out 1 one-cycle done pulse.
REQ-007 SHALL have ports: resp_data out LARGURA popped word; resp_err out 1 rejected-operation flag; both valid only in the ack cycle.
REQ-008 SHALL have stack-side ports: pilha_en out 1 operation strobe; pilha_wren out 1 (1=write, 0=read); pilha_controle out 1 (0=UC data, 1=ULA data); pilha_din_uc out LARGURA; pilha_din_ula out 32; pilha_dout in LARGURA registered read data.
REQ-009 SHALL have status ports: nivel out $clog2(PROF)+1 occupancy; cheia out 1 (nivel==PROF); vazia out 1 (nivel==0).

Function
REQ-010 SHALL implement FSM states OCIOSO, EMITE, ESPERA, RESPOSTA.
REQ-011 In OCIOSO with exactly one req high, SHALL grant that requester and latch its op and data at the clock edge.
REQ-012 In OCIOSO with both reqs high, SHALL grant the requester not served last (round robin); after reset, priority is UC.
REQ-013 A push with cheia=1 or a pop with vazia=1 SHALL go OCIOSO->RESPOSTA with resp_err=1, no pilha_en pulse, and nivel unchanged.
REQ-014 A legal grant SHALL go OCIOSO->EMITE; in EMITE, pilha_en=1 for exactly one cycle, with pilha_wren=op and pilha_controle = granted requester.
REQ-015 pilha_din_uc and pilha_din_ula SHALL hold the latched data from the grant edge until the next grant.
REQ-016 Push SHALL go EMITE->RESPOSTA and increment nivel at the EMITE->RESPOSTA edge.
REQ-017 Pop SHALL go EMITE->ESPERA->RESPOSTA, decrement nivel at the EMITE->ESPERA edge, and capture pilha_dout into resp_data at the ESPERA->RESPOSTA edge.
REQ-018 Latency from grant edge to the ack cycle SHALL be: push 2 cycles, pop 3 cycles, rejected operation 1 cycle.
REQ-019 In RESPOSTA, SHALL assert only the granted requester's ack for one cycle, then return to OCIOSO without sampling reqs that cycle.
REQ-020 A requester SHALL hold req, op and din stable until its ack; req still high in the cycle after ack is a new request.
REQ-021 A req dropped before ack SHALL NOT cancel a granted operation.
REQ-022 resp_data SHALL be 0 for push and rejected operations.
REQ-023 nivel SHALL saturate within 0..PROF, with no wrap-around in either direction.
REQ-024 The unserved requester SHALL wait, at most one full operation, before it is granted.

Reset
REQ-025 On rst low (asynchronous), SHALL force: state OCIOSO; every output 0 except vazia=1; round-robin priority to UC.
REQ-026 Reset mid-operation SHALL abort without any ack; the system SHALL reset the stack index together with this block so that nivel=0 stays consistent.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the op encoding (PUSH=1, POP=0) and the requester encoding (UC=0, ULA=1).
REQ-028 The round-robin choice SHALL be one sub-module, arbitro_rr2: two requests in, one-hot grant and last-served register out.

Verification
REQ-029 Reset, then UC push 16'hA5A5 -> pilha_en with wren=1, controle=0, din_uc=A5A5; uc_ack 2 cycles after grant; nivel=1, vazia=0.
REQ-030 Push 16'h1111 then pop from ULA -> ula_ack 3 cycles after grant, resp_data=16'h1111, resp_err=0, nivel=0.
REQ-031 UC and ULA both push in the same cycle from reset -> UC served first, ULA second; next simultaneous pair -> order repeats as UC then ULA per round robin.
REQ-032 16 pushes then a 17th push -> resp_err=1 one cycle after grant, no pilha_en, nivel=16, cheia=1; pop on empty -> resp_err=1, nivel=0.
REQ-033 ULA push 32'hDEAD_BEEF -> controle=1, pilha_din_ula=32'hDEADBEEF; a subsequent pop returns the 16-bit word as stored by the stack.
REQ-034 Assert rst during ESPERA of a pop -> no ack ever issued, nivel=0, state OCIOSO, next UC push behaves as in REQ-029.
